// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch-controller state and fetch increment.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned WBYTES = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_if.sv
// Program-counter interface: the PC register owns pco, the fetch controller writes it.
interface pc_if;
    import cpu_types_pkg::*;

    word_t pco;
    logic  WEN;
    word_t pci;

    modport pc (input WEN, input pci, output pco);
    modport fc (input pco, output WEN, output pci);

endinterface

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: sequences imem reads, buffers a word across
// decode stalls, and defers redirects that arrive while a read is in flight.
module pc_fetch_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned PC_INC      = WBYTES,
    parameter bit          STICKY_HALT = 1'b1
) (
    input  logic  CLK,
    input  logic  nRST,
    input  word_t pco,
    output logic  WEN,
    output word_t pci,
    output logic  iREN,
    output word_t iaddr,
    input  logic  ihit,
    input  word_t iload,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_addr,
    input  logic  halt,
    output word_t instr,
    output logic  instr_valid,
    output logic  halted
);

    fetch_state_t state, next_state;
    logic         pend, pend_nxt;
    word_t        pend_addr, pend_addr_nxt;
    word_t        ibuf, ibuf_nxt;
    word_t        seq_pc;

    assign seq_pc = pco + WORD_W'(PC_INC);
    assign iaddr  = pco;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= FETCH;
            pend      <= 1'b0;
            pend_addr <= '0;
            ibuf      <= '0;
        end else begin
            state     <= next_state;
            pend      <= pend_nxt;
            pend_addr <= pend_addr_nxt;
            ibuf      <= ibuf_nxt;
        end
    end

    always_comb begin
        next_state    = state;
        pend_nxt      = pend;
        pend_addr_nxt = pend_addr;
        ibuf_nxt      = ibuf;
        WEN           = 1'b0;
        pci           = pco;
        iREN          = 1'b0;
        instr         = ibuf;
        instr_valid   = 1'b0;
        halted        = 1'b0;

        case (state)
            FETCH: begin
                iREN  = 1'b1;
                instr = iload;
                if (halt) begin
                    next_state = HALTED;
                    pend_nxt   = 1'b0;
                end else if (!ihit) begin
                    // Request stays outstanding; remember only the newest target.
                    if (redirect) begin
                        pend_nxt      = 1'b1;
                        pend_addr_nxt = redirect_addr;
                    end
                end else if (redirect || pend) begin
                    WEN      = 1'b1;
                    pci      = redirect ? redirect_addr : pend_addr;
                    pend_nxt = 1'b0;
                end else begin
                    instr_valid = 1'b1;
                    if (stall) begin
                        ibuf_nxt   = iload;
                        next_state = HOLD;
                    end else begin
                        WEN = 1'b1;
                        pci = seq_pc;
                    end
                end
            end

            HOLD: begin
                if (halt) begin
                    next_state = HALTED;
                    pend_nxt   = 1'b0;
                end else if (redirect) begin
                    WEN        = 1'b1;
                    pci        = redirect_addr;
                    next_state = FETCH;
                end else begin
                    instr_valid = 1'b1;
                    if (!stall) begin
                        WEN        = 1'b1;
                        pci        = seq_pc;
                        next_state = FETCH;
                    end
                end
            end

            HALTED: begin
                halted   = 1'b1;
                pend_nxt = 1'b0;
                if (!STICKY_HALT && !halt && redirect) begin
                    WEN        = 1'b1;
                    pci        = redirect_addr;
                    next_state = FETCH;
                end
            end

            default: begin
                next_state = FETCH;
                pend_nxt   = 1'b0;
            end
        endcase
    end

endmodule
